lif_neuron_engine: RTL and testbench
====================================

# lif_neuron_engine

Leaky-integrate-and-fire update engine for the neuromorphic core. It is the read-side consumer of the weight vector registers (WVR) and spike vector registers (SVR), which the pipeline fills at writeback.

On a `start` pulse it performs these steps:
- Reads one SVR entry as the input spike vector.
- Walks N_NEURONS WVR entries, one neuron per cycle.
- Updates an internal membrane-potential array and produces an output spike vector.

It sits beside the WVR/SVR register files and drives their read-address ports.

## Interface
- N_NEURONS, 8: neurons per timestep. Legal range 1..8; each neuron owns 4 input spike bits.
- WVR_BASE, 0: WVR index of neuron 0's weights. WVR_BASE+N_NEURONS must be ≤ 32.
- LEAK_SHIFT, 4: leak is V>>>LEAK_SHIFT per timestep. Legal range 1..15.
- THRESHOLD, 64: signed 16-bit firing threshold.
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one timestep update. Sampled only in IDLE.
- spike_sel  in  5  SVR index holding the input spikes. Latched on an accepted start.
- svr_readaddr  out  5  SVR read address (registered).
- svr_readdata  in  32  SVR read data. Combinational from the register file.
- wvr_readaddr  out  5  WVR read address.
- wvr_readdata  in  32  WVR read data. Combinational from the register file.
- busy  out  1  high from the LOAD state through the last ACCUM cycle.
- done  out  1  one-cycle pulse when spike_out is updated.
- spike_out  out  N_NEURONS  output spikes of the last timestep; bit n is neuron n.
- vmem_sel  in  3  membrane-potential readback index.
- vmem_data  out  16  V[vmem_sel], combinational. Returns 0 if vmem_sel ≥ N_NEURONS.

## Operation
- State: V[0..N_NEURONS-1] (16-bit signed), spike register, 3-bit neuron counter cnt, latched spike vector S (32 bits).
- FSM states are IDLE, LOAD, ACCUM and DONE.
  - IDLE: on start, latch spike_sel into svr_readaddr and go to LOAD.
  - LOAD: capture S = svr_readdata, set cnt = 0 and go to ACCUM.
  - ACCUM: process neuron cnt (see below). If cnt == N_NEURONS-1 go to DONE; else increment cnt.
  - DONE: assert done, copy the accumulated spike bits to spike_out, return to IDLE.
- wvr_readaddr = WVR_BASE + cnt.
- Per-neuron update for neuron n in ACCUM:
  - Weights: byte k of wvr_readdata, bits [8k+7:8k], is a signed 8-bit weight w_k for k = 0..3.
  - Synaptic sum: sum = Σ w_k over k where S[4n+k] = 1. The sum is 10-bit signed, range -512..508.
  - New potential: Vn = V[n] - (V[n]>>>LEAK_SHIFT) + sum, computed at 18-bit signed width.
  - Saturate Vn to the range -32768..32767.
  - If saturated Vn ≥ THRESHOLD (signed compare): set spike bit n = 1 and store V[n] = 0.
  - Otherwise: set spike bit n = 0 and store V[n] = saturated Vn.
- start is ignored while not in IDLE; there is no queueing.
- Start in the DONE cycle is ignored.
- V persists across timesteps; only reset clears it.
- The engine samples SVR once, in LOAD, and WVR once per neuron, in that neuron's ACCUM cycle.
- Software must not write the selected SVR entry, or WVR_BASE..WVR_BASE+N_NEURONS-1, while busy. Same-cycle write/read returns whatever the register file presents combinationally.

## Timing
- Start accepted at edge T:
  - LOAD in cycle T+1.
  - ACCUM for neuron n in cycle T+2+n.
  - DONE in cycle T+2+N_NEURONS.
- Total latency is N_NEURONS+2 cycles from start to done. With the default, done occurs 10 cycles after start.
- busy is high in cycles T+1 .. T+1+N_NEURONS and low in DONE and IDLE.
- spike_out changes only at the edge ending DONE and holds until the next DONE.
- Earliest next accepted start is in the cycle after DONE.
- Reset values:
  - state = IDLE, busy = 0, done = 0, spike_out = 0.
  - svr_readaddr = 0, cnt = 0, so wvr_readaddr = WVR_BASE.
  - all V = 0.
- Reset mid-operation:
  - Aborts immediately.
  - V values already written are cleared.
  - No done pulse is produced.
  - spike_out = 0.

## Test plan
- Reset: assert reset during ACCUM.
  - Next cycle: busy = 0, done = 0, spike_out = 0, svr_readaddr = 0, wvr_readaddr = 0, all vmem_data = 0.
- Integration and fire (defaults): set SVR[3] = 0x0000000F and WVR[0] = 0x05050505; issue four starts with spike_sel = 3.
  - V0 after each start: 20, 39, 57, then 74 ≥ 64 fires.
  - After the fourth start: spike_out = 0x01 and V0 = 0; V1..V7 stay 0.
- Latency and masking: issue start, then hold start high for 12 cycles.
  - done rises exactly 10 cycles after the first accepted start.
  - Only two timesteps execute: starts are ignored while busy and in DONE.
- Negative weights and leak: set SVR[1] = 0x000000F0 and WVR[1] = 0xF0F0F0F0 (four weights of -16); issue start with spike_sel = 1.
  - V1 = -64 and no spike.
  - Next start: -64 - (-4) - 64 = -124.
- Saturation: instantiate with LEAK_SHIFT = 15 and THRESHOLD = 32767; set WVR[0] = 0x7F7F7F7F and SVR bits 3:0 set.
  - After 64 starts: V0 = 32512.
  - The 65th start saturates to 32767, fires, and V0 = 0.
- Back-to-back with a concurrent write: issue start one cycle after done.
  - The next timestep is accepted.
  - A pipeline write to an unrelated WVR entry during ACCUM does not affect results.

Source files
------------

// File: rtl/lif_neuron_engine.sv
// Leaky-integrate-and-fire timestep engine: reads one SVR spike vector, then one
// WVR weight word per neuron. It updates the membrane potentials and emits a spike vector.
// Latency N_NEURONS+2 cycles from accepted start to done; start is ignored unless IDLE.
module lif_neuron_engine #(
  parameter int                 N_NEURONS  = 8,
  parameter int                 WVR_BASE   = 0,
  parameter int                 LEAK_SHIFT = 4,
  parameter logic signed [15:0] THRESHOLD  = 16'sd64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           spike_sel,
  output logic [4:0]           svr_readaddr,
  input  logic [31:0]          svr_readdata,
  output logic [4:0]           wvr_readaddr,
  input  logic [31:0]          wvr_readdata,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spike_out,
  input  logic [2:0]           vmem_sel,
  output logic [15:0]          vmem_data
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DONE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            svr_addr_q, svr_addr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           s_q, s_d;
  logic [N_NEURONS-1:0]  spk_acc_q, spk_acc_d;
  logic [N_NEURONS-1:0]  spike_out_q, spike_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic signed [15:0]    v_q [N_NEURONS];
  logic signed [15:0]    v_d [N_NEURONS];

  // Datapath for the neuron currently addressed by cnt_q
  logic [3:0]            s_nib;
  logic signed [9:0]     syn_sum;
  logic signed [15:0]    v_cur;
  logic signed [15:0]    v_leak;
  logic signed [17:0]    v_new;
  logic signed [15:0]    v_sat;
  logic                  fire;

  assign s_nib        = s_q[{cnt_q, 2'b00} +: 4];
  assign wvr_readaddr = 5'(WVR_BASE) + {2'b00, cnt_q};
  assign svr_readaddr = svr_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign spike_out    = spike_out_q;

  // Synaptic sum, leak, saturation and threshold decision for neuron cnt_q
  always_comb begin
    syn_sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (s_nib[k]) begin
        syn_sum = syn_sum + $signed({{2{wvr_readdata[8*k+7]}}, wvr_readdata[8*k +: 8]});
      end
    end
    // Mux instead of direct indexing keeps N_NEURONS < 8 from reading past the array
    v_cur = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (cnt_q == 3'(i)) v_cur = v_q[i];
    end
    v_leak = v_cur >>> LEAK_SHIFT;
    v_new  = $signed({{2{v_cur[15]}}, v_cur})
           - $signed({{2{v_leak[15]}}, v_leak})
           + $signed({{8{syn_sum[9]}}, syn_sum});
    if (v_new > 18'sd32767)       v_sat = 16'sh7FFF;
    else if (v_new < -18'sd32768) v_sat = 16'sh8000;
    else                          v_sat = v_new[15:0];
    fire = (v_sat >= THRESHOLD);
  end

  // Next-state for the control FSM and all datapath registers
  always_comb begin
    state_d     = state_q;
    svr_addr_d  = svr_addr_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    spk_acc_d   = spk_acc_q;
    spike_out_d = spike_out_q;
    v_d         = v_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          svr_addr_d = spike_sel;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        s_d     = svr_readdata;
        cnt_d   = 3'd0;
        state_d = ACCUM;
      end
      ACCUM: begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (cnt_q == 3'(i)) begin
            v_d[i]       = fire ? 16'sd0 : v_sat;
            spk_acc_d[i] = fire;
          end
        end
        if (cnt_q == 3'(N_NEURONS - 1)) state_d = DONE;
        else                            cnt_d   = cnt_q + 3'd1;
      end
      DONE: begin
        spike_out_d = spk_acc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered and track the state being entered
    busy_d = (state_d == LOAD) || (state_d == ACCUM);
    done_d = (state_d == DONE);
  end

  // Register update; reset aborts any timestep and clears all potentials
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      svr_addr_q  <= '0;
      cnt_q       <= '0;
      s_q         <= '0;
      spk_acc_q   <= '0;
      spike_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) v_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      svr_addr_q  <= svr_addr_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      spk_acc_q   <= spk_acc_d;
      spike_out_q <= spike_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < N_NEURONS; i++) v_q[i] <= v_d[i];
    end
  end

  // Membrane-potential readback; indices beyond the neuron count read as zero
  always_comb begin
    vmem_data = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (vmem_sel == 3'(i)) vmem_data = v_q[i];
    end
  end

endmodule

// File: tb/tb_lif_neuron_engine.sv
// Directed bench for lif_neuron_engine: default instance plus a small saturating instance.
// Register files are modelled as combinational-read arrays.
module tb_lif_neuron_engine;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default instance (8 neurons, leak 4, threshold 64)
  logic        reset, start_a;
  logic [4:0]  sel_a, svr_addr_a, wvr_addr_a;
  logic [31:0] svr_rd_a, wvr_rd_a;
  logic        busy_a, done_a;
  logic [7:0]  spk_a;
  logic [2:0]  vsel_a;
  logic [15:0] vdat_a;
  logic [31:0] svr_a [32];
  logic [31:0] wvr_a [32];

  assign svr_rd_a = svr_a[svr_addr_a];
  assign wvr_rd_a = wvr_a[wvr_addr_a];

  lif_neuron_engine dut_a (
    .clk(clk), .reset(reset), .start(start_a), .spike_sel(sel_a),
    .svr_readaddr(svr_addr_a), .svr_readdata(svr_rd_a),
    .wvr_readaddr(wvr_addr_a), .wvr_readdata(wvr_rd_a),
    .busy(busy_a), .done(done_a), .spike_out(spk_a),
    .vmem_sel(vsel_a), .vmem_data(vdat_a)
  );

  // Saturation instance (4 neurons, no effective leak, threshold at max)
  logic        start_b;
  logic [4:0]  sel_b, svr_addr_b, wvr_addr_b;
  logic [31:0] svr_rd_b, wvr_rd_b;
  logic        busy_b, done_b;
  logic [3:0]  spk_b;
  logic [2:0]  vsel_b;
  logic [15:0] vdat_b;
  logic [31:0] svr_b [32];
  logic [31:0] wvr_b [32];

  assign svr_rd_b = svr_b[svr_addr_b];
  assign wvr_rd_b = wvr_b[wvr_addr_b];

  lif_neuron_engine #(.N_NEURONS(4), .WVR_BASE(0), .LEAK_SHIFT(15), .THRESHOLD(16'sd32767)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .spike_sel(sel_b),
    .svr_readaddr(svr_addr_b), .svr_readdata(svr_rd_b),
    .wvr_readaddr(wvr_addr_b), .wvr_readdata(wvr_rd_b),
    .busy(busy_b), .done(done_b), .spike_out(spk_b),
    .vmem_sel(vsel_b), .vmem_data(vdat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_va(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    vsel_a = idx;
    #1;
    chk(tag, {16'h0, vdat_a}, {16'h0, exp});
  endtask

  task automatic chk_vb(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    vsel_b = idx;
    #1;
    chk(tag, {16'h0, vdat_b}, {16'h0, exp});
  endtask

  // One timestep on instance A; optionally writes an unrelated WVR entry mid-ACCUM.
  // Returns in the IDLE cycle right after DONE.
  task automatic run_a(input logic [4:0] sel, input bit poke);
    bit got;
    sel_a   = sel;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("accept_busy", {31'h0, busy_a}, 32'h1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done_a) got = 1'b1;
      else begin
        @(posedge clk); #1;
        if (poke && i == 1) wvr_a[20] = 32'hFFFF_FFFF;
      end
    end
    chk("done_seen_a", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic [4:0] sel);
    bit got;
    sel_b   = sel;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done_b) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) chk("done_seen_b", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
  endtask

  int  first_done, ndone;
  logic busy9, busy10;

  initial begin
    for (int i = 0; i < 32; i++) begin
      svr_a[i] = '0; wvr_a[i] = '0; svr_b[i] = '0; wvr_b[i] = '0;
    end
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    sel_a = '0; sel_b = '0; vsel_a = '0; vsel_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_done", {31'h0, done_a}, 32'h0);
    chk("rst_spike", {24'h0, spk_a}, 32'h0);
    chk("rst_svr_addr", {27'h0, svr_addr_a}, 32'h0);
    chk("rst_wvr_addr", {27'h0, wvr_addr_a}, 32'h0);
    for (int n = 0; n < 8; n++) chk_va("rst_vmem", 3'(n), 16'h0000);

    // Integration and fire on neuron 0
    svr_a[3] = 32'h0000_000F;
    wvr_a[0] = 32'h0505_0505;
    run_a(5'd3, 1'b0); chk_va("int_v0_1", 3'd0, 16'd20);
    run_a(5'd3, 1'b0); chk_va("int_v0_2", 3'd0, 16'd39);
    run_a(5'd3, 1'b0); chk_va("int_v0_3", 3'd0, 16'd57);
    chk("int_spike_3", {24'h0, spk_a}, 32'h0);
    run_a(5'd3, 1'b0); chk_va("int_v0_4", 3'd0, 16'd0);
    chk("int_spike_4", {24'h0, spk_a}, 32'h1);
    for (int n = 1; n < 8; n++) chk_va("int_vrest", 3'(n), 16'h0000);

    // Reset during ACCUM after neuron 0 has been written
    sel_a = 5'd3; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy", {31'h0, busy_a}, 32'h1);
    chk("mid_svr_addr", {27'h0, svr_addr_a}, 32'h3);
    chk_va("mid_v0_written", 3'd0, 16'd20);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_busy", {31'h0, busy_a}, 32'h0);
    chk("mr_done", {31'h0, done_a}, 32'h0);
    chk("mr_spike", {24'h0, spk_a}, 32'h0);
    chk("mr_svr_addr", {27'h0, svr_addr_a}, 32'h0);
    chk("mr_wvr_addr", {27'h0, wvr_addr_a}, 32'h0);
    for (int n = 0; n < 8; n++) chk_va("mr_vmem", 3'(n), 16'h0000);

    // Latency and start masking: start held for 12 cycles
    sel_a = 5'd3; start_a = 1'b1;
    first_done = 0; ndone = 0; busy9 = 1'b0; busy10 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 12) start_a = 1'b0;
      if (done_a) begin
        ndone++;
        if (first_done == 0) first_done = i;
      end
      if (i == 9)  busy9  = busy_a;
      if (i == 10) busy10 = busy_a;
    end
    chk("lat_first_done", 32'(first_done), 32'd10);
    chk("lat_num_done", 32'(ndone), 32'd2);
    chk("lat_busy_last_accum", {31'h0, busy9}, 32'h1);
    chk("lat_busy_in_done", {31'h0, busy10}, 32'h0);
    chk_va("lat_v0", 3'd0, 16'd39);

    // Negative weights and leak on neuron 1
    svr_a[1] = 32'h0000_00F0;
    wvr_a[1] = 32'hF0F0_F0F0;
    run_a(5'd1, 1'b0);
    chk_va("neg_v1_1", 3'd1, 16'hFFC0);
    chk_va("neg_v0_1", 3'd0, 16'd37);
    chk("neg_spike_1", {24'h0, spk_a}, 32'h0);
    run_a(5'd1, 1'b0);
    chk_va("neg_v1_2", 3'd1, 16'hFF84);
    chk_va("neg_v0_2", 3'd0, 16'd35);

    // Back-to-back starts with an unrelated WVR write during ACCUM
    run_a(5'd3, 1'b1);
    chk_va("b2b_v0_1", 3'd0, 16'd53);
    chk_va("b2b_v1_1", 3'd1, 16'hFF8C);
    chk("b2b_spike_1", {24'h0, spk_a}, 32'h0);
    run_a(5'd3, 1'b0);
    chk_va("b2b_v0_2", 3'd0, 16'd0);
    chk_va("b2b_v1_2", 3'd1, 16'hFF94);
    chk("b2b_spike_2", {24'h0, spk_a}, 32'h1);

    // Saturation on the 4-neuron instance
    svr_b[0] = 32'h0000_000F;
    wvr_b[0] = 32'h7F7F_7F7F;
    for (int t = 0; t < 64; t++) run_b(5'd0);
    chk_vb("sat_v0_64", 3'd0, 16'd32512);
    chk("sat_spike_64", {28'h0, spk_b}, 32'h0);
    chk_vb("sat_vsel_oob", 3'd4, 16'h0000);
    run_b(5'd0);
    chk_vb("sat_v0_65", 3'd0, 16'd0);
    chk("sat_spike_65", {28'h0, spk_b}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
